// File: rtl/vliw_issue_ctrl.sv
// vliw_issue_ctrl: multi-slot VLIW issue controller.
// Decodes every 16-bit slot of a bundle into RegWrite/MemWrite/illegal.
// Same-bundle destination conflicts are resolved so that the highest slot wins.
// The bundle is issued through a one-deep registered output stage.
// Optional feature macro: VLIW_ISSUE_SCOREBOARD_EN.
//   When defined, per-register countdown counters track in-flight writes.
//   Issue stalls on a read or write of a pending register, and those stalls are counted.
//   When undefined, the hazard logic is absent and stall_cnt reads 0.
// Handshake: a transfer happens on a rising edge where valid && ready are both high.
//   in_valid must not depend on in_ready.
//   in_ready depends combinationally on in_bundle, the scoreboard and out_ready.
//   Outputs hold stable while out_valid && !out_ready.
module vliw_issue_ctrl #(
  parameter int NUM_SLOTS  = 2,
  parameter int REG_ADDR_W = 4,
  parameter int SRC_W      = 8,
  parameter int WB_LAT     = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_SLOTS*16-1:0]         in_bundle,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_SLOTS-1:0]            out_reg_write,
  output logic [NUM_SLOTS-1:0]            out_mem_write,
  output logic [NUM_SLOTS*REG_ADDR_W-1:0] out_dest,
  output logic [NUM_SLOTS*SRC_W-1:0]      out_src,
  output logic [NUM_SLOTS-1:0]            out_illegal,
  output logic                            waw_conflict,
  output logic [15:0]                     stall_cnt
);

  logic [NUM_SLOTS-1:0][2:0]            slotOp;
  logic [NUM_SLOTS-1:0][REG_ADDR_W-1:0] slotDest;
  logic [NUM_SLOTS-1:0][SRC_W-1:0]      slotSrc;
  logic [NUM_SLOTS-1:0]                 rwRaw;
  logic [NUM_SLOTS-1:0]                 rwFinal;
  logic [NUM_SLOTS-1:0]                 slotMw;
  logic [NUM_SLOTS-1:0]                 slotIll;
  logic                                 wawAny;
  logic                                 hazard;
  logic                                 accept;

  // Split each slot into fields and apply the opcode decode table
  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      slotOp[i]   = in_bundle[16*i+13 +: 3];
      slotDest[i] = REG_ADDR_W'(in_bundle[16*i+8 +: 4]);
      slotSrc[i]  = SRC_W'(in_bundle[16*i +: 8]);
      rwRaw[i]    = 1'b0;
      slotMw[i]   = 1'b0;
      slotIll[i]  = 1'b0;
      case (slotOp[i])
        3'b001, 3'b010, 3'b011, 3'b101, 3'b110: rwRaw[i] = 1'b1;
        3'b100:                                 slotMw[i] = 1'b1;
        3'b111:                                 slotIll[i] = 1'b1;
        default: ;
      endcase
    end
  end

  // Same-bundle WAW: a lower slot loses RegWrite if any higher slot writes the same register
  always_comb begin
    rwFinal = rwRaw;
    wawAny  = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      for (int j = i + 1; j < NUM_SLOTS; j++) begin
        if (rwRaw[i] && rwRaw[j] && (slotDest[i] == slotDest[j])) begin
          rwFinal[i] = 1'b0;
          wawAny     = 1'b1;
        end
      end
    end
  end

  assign in_ready = (!out_valid || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

`ifdef VLIW_ISSUE_SCOREBOARD_EN
  localparam int NUM_REGS = 1 << REG_ADDR_W;
  localparam int CNT_W    = $clog2(WB_LAT + 1);

  logic [NUM_REGS-1:0][CNT_W-1:0] regCnt;
  logic [NUM_REGS-1:0]            pending;
  logic [NUM_REGS-1:0]            loadReg;
  logic [NUM_SLOTS-1:0]           slotImm;
  logic                           hazardRaw;

  // A register is pending while its writeback countdown is nonzero
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) pending[r] = (regCnt[r] != '0);
  end

  // Hazard: any register source read, STORE destination read, or surviving write hits a pending register
  always_comb begin
    hazardRaw = 1'b0;
    loadReg   = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      slotImm[i] = in_bundle[16*i+12];
      if (!slotImm[i] && pending[slotSrc[i][REG_ADDR_W-1:0]]) hazardRaw = 1'b1;
      if (slotMw[i] && pending[slotDest[i]])                  hazardRaw = 1'b1;
      if (rwFinal[i] && pending[slotDest[i]])                 hazardRaw = 1'b1;
      if (accept && rwFinal[i])                               loadReg[slotDest[i]] = 1'b1;
    end
  end

  assign hazard = in_valid && hazardRaw;

  // Countdown per register; a fresh load takes priority over the decrement
  always_ff @(posedge clk) begin
    for (int r = 0; r < NUM_REGS; r++) begin
      if (rst)                  regCnt[r] <= '0;
      else if (loadReg[r])      regCnt[r] <= CNT_W'(WB_LAT);
      else if (regCnt[r] != '0) regCnt[r] <= regCnt[r] - 1'b1;
    end
  end

  // Count hazard-stall cycles only, saturating at all-ones
  always_ff @(posedge clk) begin
    if (rst)                                   stall_cnt <= '0;
    else if (hazard && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
  end
`else
  assign hazard    = 1'b0;
  assign stall_cnt = '0;
`endif

  // Output stage: load on accept, drop valid once consumed with nothing new behind it
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_reg_write <= '0;
      out_mem_write <= '0;
      out_dest      <= '0;
      out_src       <= '0;
      out_illegal   <= '0;
      waw_conflict  <= 1'b0;
    end else if (accept) begin
      out_valid     <= 1'b1;
      out_reg_write <= rwFinal;
      out_mem_write <= slotMw;
      out_dest      <= slotDest;
      out_src       <= slotSrc;
      out_illegal   <= slotIll;
      waw_conflict  <= wawAny;
    end else if (out_ready) begin
      out_valid     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vliw_issue_ctrl.sv
// Directed bench for vliw_issue_ctrl (NUM_SLOTS=2, WB_LAT=3).
// Expected output records are queued on every accepted bundle and compared when the output fires.
module tb_vliw_issue_ctrl;

`ifdef VLIW_ISSUE_SCOREBOARD_EN
  localparam bit SB_EN = 1'b1;
`else
  localparam bit SB_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_bundle;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_reg_write;
  logic [1:0]  out_mem_write;
  logic [7:0]  out_dest;
  logic [15:0] out_src;
  logic [1:0]  out_illegal;
  logic        waw_conflict;
  logic [15:0] stall_cnt;

  int checks   = 0;
  int failures = 0;
  logic [30:0] exp_q[$];
  int exp_stall = 0;
  int stalls;

  vliw_issue_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_bundle(in_bundle),
    .out_valid(out_valid), .out_ready(out_ready), .out_reg_write(out_reg_write),
    .out_mem_write(out_mem_write), .out_dest(out_dest), .out_src(out_src),
    .out_illegal(out_illegal), .waw_conflict(waw_conflict), .stall_cnt(stall_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mk(input logic [2:0] op, input logic am, input logic [3:0] d,
                                     input logic [7:0] s);
    return {op, am, d, s};
  endfunction

  // Reference decode of one bundle: {rw, mw, dest, src, illegal, waw}
  function automatic logic [30:0] expect_out(input logic [31:0] b);
    logic [1:0] rw, mw, ill;
    logic [7:0] dst;
    logic [15:0] src;
    logic waw;
    logic [2:0] op;
    for (int s = 0; s < 2; s++) begin
      op = b[16*s+13 +: 3];
      rw[s]  = (op == 3'd1) || (op == 3'd2) || (op == 3'd3) || (op == 3'd5) || (op == 3'd6);
      mw[s]  = (op == 3'd4);
      ill[s] = (op == 3'd7);
      dst[4*s +: 4] = b[16*s+8 +: 4];
      src[8*s +: 8] = b[16*s +: 8];
    end
    waw = rw[0] && rw[1] && (dst[3:0] == dst[7:4]);
    if (waw) rw[0] = 1'b0;
    return {rw, mw, dst, src, ill, waw};
  endfunction

  // scoreboard: pop on output fire, push on input accept
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) check("unexpected_output", {63'd0, out_valid}, 64'd0);
        else check("out_record", {33'd0, out_reg_write, out_mem_write, out_dest, out_src,
                                  out_illegal, waw_conflict}, {33'd0, exp_q.pop_front()});
      end
      if (in_valid === 1'b1 && in_ready === 1'b1) exp_q.push_back(expect_out(in_bundle));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] s1, input logic [15:0] s0);
    in_valid  = v;
    in_bundle = {s1, s0};
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b1;
    drive(1'b0, 16'h0, 16'h0);
    repeat (3) tick();
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_reg_write", {62'd0, out_reg_write}, 64'd0);
    check("rst_dest", {56'd0, out_dest}, 64'd0);
    check("rst_waw", {63'd0, waw_conflict}, 64'd0);
    check("rst_stall_cnt", {48'd0, stall_cnt}, 64'd0);
    rst = 1'b0;

    // 1: {NOP, STORE}
    drive(1'b1, mk(3'd4, 1'b1, 4'd1, 8'h10), mk(3'd0, 1'b1, 4'd0, 8'h00));
    #1 check("t1_in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    drive(1'b0, 16'h0, 16'h0);
    check("t1_out_valid", {63'd0, out_valid}, 64'd1);
    check("t1_reg_write", {62'd0, out_reg_write}, 64'd0);
    check("t1_mem_write", {62'd0, out_mem_write}, 64'd2);
    check("t1_illegal", {62'd0, out_illegal}, 64'd0);

    // 2: ADD d=5 / SUB d=5 -> higher slot wins
    drive(1'b1, mk(3'd2, 1'b1, 4'd5, 8'h22), mk(3'd1, 1'b1, 4'd5, 8'h11));
    tick();
    drive(1'b0, 16'h0, 16'h0);
    check("t2_reg_write", {62'd0, out_reg_write}, 64'd2);
    check("t2_waw", {63'd0, waw_conflict}, 64'd1);
    repeat (4) tick();

    // 3: ADD d=3, one idle cycle, then a bundle reading r3
    drive(1'b1, mk(3'd0, 1'b1, 4'd0, 8'h00), mk(3'd1, 1'b1, 4'd3, 8'h40));
    tick();
    drive(1'b0, 16'h0, 16'h0);
    tick();
    drive(1'b1, mk(3'd0, 1'b1, 4'd0, 8'h00), mk(3'd1, 1'b0, 4'd9, 8'h03));
    stalls = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (in_ready === 1'b1) break;
      stalls++;
      @(posedge clk);
    end
    check("t3_ready_after_stall", {63'd0, in_ready}, 64'd1);
    check("t3_stall_cycles", 64'(stalls), SB_EN ? 64'd2 : 64'd0);
    tick();
    drive(1'b0, 16'h0, 16'h0);
    exp_stall += SB_EN ? 2 : 0;
    check("t3_stall_cnt", {48'd0, stall_cnt}, 64'(exp_stall));
    repeat (4) tick();

    // 4: same but immediate operand -> back-to-back
    drive(1'b1, mk(3'd0, 1'b1, 4'd0, 8'h00), mk(3'd1, 1'b1, 4'd3, 8'h40));
    tick();
    drive(1'b1, mk(3'd0, 1'b1, 4'd0, 8'h00), mk(3'd1, 1'b1, 4'd10, 8'h03));
    #1 check("t4_in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    drive(1'b0, 16'h0, 16'h0);
    check("t4_stall_cnt", {48'd0, stall_cnt}, 64'(exp_stall));
    repeat (4) tick();

    // 5: backpressure with two bundles offered
    out_ready = 1'b0;
    drive(1'b1, mk(3'd0, 1'b1, 4'd0, 8'h00), mk(3'd6, 1'b1, 4'd11, 8'hA1));
    tick();
    drive(1'b1, mk(3'd5, 1'b1, 4'd13, 8'hB2), mk(3'd4, 1'b1, 4'd12, 8'h55));
    #1 check("t5_bp_in_ready", {63'd0, in_ready}, 64'd0);
    tick();
    tick();
    check("t5_hold_valid", {63'd0, out_valid}, 64'd1);
    check("t5_hold_dest", {56'd0, out_dest}, 64'h0B);
    check("t5_hold_reg_write", {62'd0, out_reg_write}, 64'd1);
    check("t5_bp_no_stall", {48'd0, stall_cnt}, 64'(exp_stall));
    out_ready = 1'b1;
    #1 check("t5_release_ready", {63'd0, in_ready}, 64'd1);
    tick();
    drive(1'b0, 16'h0, 16'h0);
    check("t5_second_dest", {56'd0, out_dest}, 64'hDC);
    check("t5_second_mem_write", {62'd0, out_mem_write}, 64'd1);
    check("t5_second_reg_write", {62'd0, out_reg_write}, 64'd2);
    tick();
    check("t5_drained", {63'd0, out_valid}, 64'd0);
    repeat (4) tick();

    // 6: illegal slot, then reset while holding output with r14 pending
    drive(1'b1, mk(3'd3, 1'b1, 4'd14, 8'h07), mk(3'd7, 1'b1, 4'd2, 8'h00));
    tick();
    drive(1'b0, 16'h0, 16'h0);
    out_ready = 1'b0;
    check("t6_illegal", {62'd0, out_illegal}, 64'd1);
    check("t6_reg_write", {62'd0, out_reg_write}, 64'd2);
    check("t6_mem_write", {62'd0, out_mem_write}, 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    exp_stall = 0;
    check("t6_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("t6_rst_illegal", {62'd0, out_illegal}, 64'd0);
    check("t6_rst_stall_cnt", {48'd0, stall_cnt}, 64'd0);
    out_ready = 1'b1;
    drive(1'b1, mk(3'd0, 1'b1, 4'd0, 8'h00), mk(3'd1, 1'b0, 4'd4, 8'h0E));
    #1 check("t6_no_stale_hazard", {63'd0, in_ready}, 64'd1);
    tick();
    drive(1'b0, 16'h0, 16'h0);
    check("t6_post_rst_valid", {63'd0, out_valid}, 64'd1);
    repeat (3) tick();
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
